// File: rtl/lift_req_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lift_req_pkg
//  Brief  : Shared types, FIFO word field positions and word packing helpers
//           for the parking-lift request writer.
//  Rev    : 1.0  initial release
// ============================================================================
package lift_req_pkg;

    // Request operation codes carried on req_op
    typedef enum logic [1:0] {
        OP_ILLEGAL  = 2'b00,
        OP_PARK     = 2'b01,
        OP_RETRIEVE = 2'b10,
        OP_CANCEL   = 2'b11
    } req_op_e;

    // Writer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_e;

    localparam int WORD_W   = 12;

    // Header word fields
    localparam int SOF_BIT  = 11;
    localparam int OP_HI    = 10;
    localparam int OP_LO    = 9;
    localparam int FLOOR_HI = 8;
    localparam int FLOOR_LO = 5;
    localparam int SEQ_HI   = 4;
    localparam int SEQ_LO   = 0;

    // Payload word fields
    localparam int SLOT_HI  = 10;
    localparam int SLOT_LO  = 5;
    localparam int CAR_HI   = 4;
    localparam int CAR_LO   = 0;

    // Header word: start-of-frame bit set so the consumer can resynchronise
    function automatic logic [WORD_W-1:0] pack_hdr(
        input logic [1:0] op,
        input logic [3:0] floor,
        input logic [4:0] seq
    );
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[SOF_BIT]           = 1'b1;
        w[OP_HI:OP_LO]       = op;
        w[FLOOR_HI:FLOOR_LO] = floor;
        w[SEQ_HI:SEQ_LO]     = seq;
        return w;
    endfunction

    // Payload word: start-of-frame bit clear
    function automatic logic [WORD_W-1:0] pack_pld(
        input logic [5:0] slot,
        input logic [4:0] car_id
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[SLOT_HI:SLOT_LO] = slot;
        w[CAR_HI:CAR_LO]   = car_id;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_req_writer_if.sv
`default_nettype none
// ============================================================================
//  Module : lift_req_writer_if
//  Brief  : Request handshake plus FIFO write-side bundle for the lift request
//           writer. master = the writer, slave = requester/FIFO environment.
//  Rev    : 1.0  initial release
// ============================================================================
interface lift_req_writer_if #(
    parameter int DATASIZE = 12
) ();

    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [3:0]          req_floor;
    logic [5:0]          req_slot;
    logic [4:0]          req_car_id;

    logic                write_full;
    logic                write_enable;
    logic [DATASIZE-1:0] write_data;

    modport master (
        input  req_valid, req_op, req_floor, req_slot, req_car_id, write_full,
        output req_ready, write_enable, write_data
    );

    modport slave (
        output req_valid, req_op, req_floor, req_slot, req_car_id, write_full,
        input  req_ready, write_enable, write_data
    );

endinterface
`default_nettype wire

// File: rtl/lift_req_writer.sv
`default_nettype none
// ============================================================================
//  Module : lift_req_writer
//  Brief  : Write-clock-side producer for the parking-lift async FIFO. Takes
//           one request at a time, emits a header word then a payload word,
//           and keeps a rolling sequence number plus done/drop counters.
//           Optional HDR stall timeout: define LIFT_REQ_STALL_TIMEOUT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module lift_req_writer
    import lift_req_pkg::*;
#(
    parameter int DATASIZE    = 12,
    parameter int SEQ_W       = 5,
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 255
) (
    input  wire logic              write_clk,
    input  wire logic              read_reset_n,
    lift_req_writer_if.master      bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   stall_abort
);

    // Elaboration-time parameter sanity
    if (DATASIZE != 12) begin : g_bad_datasize
        $error("lift_req_writer: DATASIZE must be 12");
    end
    if (1 + 2 + 4 + SEQ_W != DATASIZE) begin : g_bad_seq_w
        $error("lift_req_writer: 1+2+4+SEQ_W must equal DATASIZE");
    end
    if (STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_stall_limit
        $error("lift_req_writer: STALL_LIMIT must be within 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [1:0]         op_q;
    logic [3:0]         floor_q;
    logic [5:0]         slot_q;
    logic [4:0]         car_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [CNT_W-1:0]   done_cnt_q;
    logic [CNT_W-1:0]   drop_cnt_q;

`ifdef LIFT_REQ_STALL_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);
    logic [7:0]         stall_cnt_q;
    logic               stall_abort_q;
    assign stall_abort = stall_abort_q;
`else
    assign stall_abort = 1'b0;
`endif

    assign done_cnt = done_cnt_q;
    assign drop_cnt = drop_cnt_q;

    // Frame FSM, holding registers, sequence number and statistics counters
    always_ff @(posedge write_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            floor_q    <= '0;
            slot_q     <= '0;
            car_q      <= '0;
            seq_q      <= '0;
            done_cnt_q <= '0;
            drop_cnt_q <= '0;
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
            stall_cnt_q   <= '0;
            stall_abort_q <= 1'b0;
`endif
        end else begin
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
            stall_abort_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_op != OP_ILLEGAL) begin
                            op_q    <= bus.req_op;
                            floor_q <= bus.req_floor;
                            slot_q  <= bus.req_slot;
                            car_q   <= bus.req_car_id;
                            state_q <= HDR;
                        end else if (drop_cnt_q != '1) begin
                            // Illegal op is consumed and counted, never written
                            drop_cnt_q <= drop_cnt_q + CNT_ONE;
                        end
                    end
                end
                HDR: begin
                    if (!bus.write_full) begin
                        state_q <= PLD;
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
                        stall_cnt_q <= '0;
`endif
                    end
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
                    else if (stall_cnt_q == STALL_LAST) begin
                        // Nothing of this frame reached the FIFO yet, so it
                        // can be abandoned without leaving a half frame.
                        state_q       <= IDLE;
                        stall_cnt_q   <= '0;
                        stall_abort_q <= 1'b1;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_q <= drop_cnt_q + CNT_ONE;
                        end
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 8'd1;
                    end
`endif
                end
                PLD: begin
                    // Header is already in the FIFO: payload waits as long as needed
                    if (!bus.write_full) begin
                        state_q    <= IDLE;
                        seq_q      <= seq_q + SEQ_ONE;
                        done_cnt_q <= done_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and FIFO word decode from the current state
    always_comb begin
        bus.req_ready    = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_data   = '0;
        busy             = 1'b1;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            HDR: begin
                bus.write_enable = 1'b1;
                bus.write_data   = pack_hdr(op_q, floor_q, seq_q);
            end
            PLD: begin
                bus.write_enable = 1'b1;
                bus.write_data   = pack_pld(slot_q, car_q);
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lift_req_writer.sv
`default_nettype none
// ============================================================================
//  Module : tb_lift_req_writer
//  Brief  : Self-checking bench for lift_req_writer. A word-queue reference
//           model predicts the FIFO word stream, handshake and counters.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_lift_req_writer;

    localparam int STALL_LIMIT_TB = 5;

    logic       write_clk = 1'b0;
    logic       read_reset_n;
    logic       busy;
    logic [7:0] done_cnt;
    logic [7:0] drop_cnt;
    logic       stall_abort;

    lift_req_writer_if #(.DATASIZE(12)) bus ();

    lift_req_writer #(
        .DATASIZE    (12),
        .SEQ_W       (5),
        .CNT_W       (8),
        .STALL_LIMIT (STALL_LIMIT_TB)
    ) u_dut (
        .write_clk    (write_clk),
        .read_reset_n (read_reset_n),
        .bus          (bus),
        .busy         (busy),
        .done_cnt     (done_cnt),
        .drop_cnt     (drop_cnt),
        .stall_abort  (stall_abort)
    );

    always #5 write_clk = ~write_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: words still owed to the FIFO, plus counters
    logic [11:0] exp_q[$];
    int          m_done;
    int          m_drop;
    int          m_seq;
    int          m_run;
    bit          m_abort;

    task automatic model_reset();
        exp_q.delete();
        m_done  = 0;
        m_drop  = 0;
        m_seq   = 0;
        m_run   = 0;
        m_abort = 0;
    endtask

    // Predict the effect of the coming clock edge given the driven inputs
    task automatic model_step(input bit valid, input logic [1:0] op, input logic [3:0] fl,
                              input logic [5:0] sl, input logic [4:0] car, input bit full);
        logic [11:0] w;
        logic [4:0]  s;
        m_abort = 0;
        if (exp_q.size() == 0) begin
            m_run = 0;
            if (valid) begin
                if (op != 2'b00) begin
                    s = m_seq[4:0];
                    exp_q.push_back({1'b1, op, fl, s});
                    exp_q.push_back({1'b0, sl, car});
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end else if (!full) begin
            w     = exp_q.pop_front();
            m_run = 0;
            if (!w[11]) begin
                m_done = (m_done + 1) % 256;
                m_seq  = (m_seq + 1) % 32;
            end
        end else if (exp_q[0][11]) begin
            m_run++;
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
            if (m_run == STALL_LIMIT_TB) begin
                exp_q.delete();
                m_run   = 0;
                m_abort = 1;
                if (m_drop < 255) m_drop++;
            end
`endif
        end
    endtask

    task automatic check_all(input string ctx);
        bit pend;
        pend = (exp_q.size() != 0);
        check_eq({ctx, ".ready"}, {31'd0, bus.req_ready}, {31'd0, !pend});
        check_eq({ctx, ".we"},    {31'd0, bus.write_enable}, {31'd0, pend});
        check_eq({ctx, ".data"},  {20'd0, bus.write_data}, pend ? {20'd0, exp_q[0]} : 32'd0);
        check_eq({ctx, ".busy"},  {31'd0, busy}, {31'd0, pend});
        check_eq({ctx, ".done"},  {24'd0, done_cnt}, m_done);
        check_eq({ctx, ".drop"},  {24'd0, drop_cnt}, m_drop);
        check_eq({ctx, ".abort"}, {31'd0, stall_abort}, {31'd0, m_abort});
    endtask

    // One clock: drive at the negedge, predict, then check at the next negedge
    task automatic step(input string ctx, input bit valid, input logic [1:0] op, input logic [3:0] fl,
                        input logic [5:0] sl, input logic [4:0] car, input bit full);
        bus.req_valid  = valid;
        bus.req_op     = op;
        bus.req_floor  = fl;
        bus.req_slot   = sl;
        bus.req_car_id = car;
        bus.write_full = full;
        model_step(valid, op, fl, sl, car, full);
        @(negedge write_clk);
        check_all(ctx);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_floor  = 4'd0;
        bus.req_slot   = 6'd0;
        bus.req_car_id = 5'd0;
        bus.write_full = 1'b0;
        read_reset_n   = 1'b0;
        model_reset();

        repeat (2) @(negedge write_clk);
        check_all("reset");
        read_reset_n = 1'b1;
        @(negedge write_clk);
        check_all("post_reset");

        // PARK floor 3, slot 0x2A, car 0x15
        step("park_acc", 1'b1, 2'b01, 4'd3, 6'h2A, 5'h15, 1'b0);
        check_eq("hdr_park", {20'd0, bus.write_data}, 32'hA60);
        step("park_hdr", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        check_eq("pld_park", {20'd0, bus.write_data}, 32'h555);
        step("park_pld", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        check_eq("done_1", {24'd0, done_cnt}, 32'd1);

        // RETRIEVE floor 15, same slot/car, seq now 1
        step("ret_acc", 1'b1, 2'b10, 4'd15, 6'h2A, 5'h15, 1'b0);
        check_eq("hdr_ret", {20'd0, bus.write_data}, 32'hDE1);
        step("ret_hdr", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        check_eq("pld_ret", {20'd0, bus.write_data}, 32'h555);
        step("ret_pld", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        check_eq("done_2", {24'd0, done_cnt}, 32'd2);

        // Header held for four full cycles; input churn must not leak in
        step("hold_acc", 1'b1, 2'b11, 4'd7, 6'd1, 5'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("hold_full", 1'b1, 2'b01, 4'(i), 6'h3F, 5'h1F, 1'b1);
            check_eq("hold_hdr", {20'd0, bus.write_data}, 32'hEE2);
        end
        step("hold_go", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        check_eq("hold_resume", {31'd0, bus.write_data[11]}, 32'd0);
        step("hold_pld", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);

        // Illegal op is consumed and dropped
        step("illegal", 1'b1, 2'b00, 4'd4, 6'd4, 5'd4, 1'b0);
        check_eq("drop_1", {24'd0, drop_cnt}, 32'd1);

        // Asynchronous reset while in PLD
        step("rst_acc", 1'b1, 2'b11, 4'd9, 6'd5, 5'd6, 1'b0);
        step("rst_hdr", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        #2 read_reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge write_clk);
        read_reset_n = 1'b1;
        step("seq0_acc", 1'b1, 2'b01, 4'd1, 6'd1, 5'd1, 1'b0);
        check_eq("seq_restart", {27'd0, bus.write_data[4:0]}, 32'd0);
        step("seq0_hdr", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        step("seq0_pld", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);

        // Full held through the stall window
        step("stall_acc", 1'b1, 2'b01, 4'd2, 6'd3, 5'd4, 1'b0);
        for (int i = 0; i < STALL_LIMIT_TB; i++) begin
            step("stall_full", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b1);
        end
`ifdef LIFT_REQ_STALL_TIMEOUT_EN
        check_eq("stall_pulse", {31'd0, stall_abort}, 32'd1);
        check_eq("stall_idle",  {31'd0, busy}, 32'd0);
`else
        check_eq("stall_none",  {31'd0, stall_abort}, 32'd0);
        check_eq("stall_wait",  {31'd0, busy}, 32'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            step("stall_drain", 1'b0, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        end

        // Drop counter saturation
        for (int i = 0; i < 260; i++) begin
            step("sat", 1'b1, 2'b00, 4'd0, 6'd0, 5'd0, 1'b0);
        end
        check_eq("drop_sat", {24'd0, drop_cnt}, 32'd255);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                 6'($urandom), 5'($urandom), ($urandom_range(0, 9) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift_req_writer.md
Name: lift_req_writer

Overview:
- Upstream producer for the parking-lift async FIFO, on the write-clock side.
- Accepts one car request at a time (park, retrieve or cancel) over a valid/ready handshake.
- Serialises each request into two 12-bit FIFO words, a header then a payload, and honours the FIFO's registered full flag.
- Tracks a rolling sequence number plus completed and dropped request counters for the lift controller.

Parameters:
- DATASIZE, 12, FIFO word width; must equal 12 (elaboration-time assertion).
- SEQ_W, 5, sequence-number width; must satisfy 1 + 2 + 4 + SEQ_W == DATASIZE.
- CNT_W, 8, width of the statistics counters.
- STALL_LIMIT, 255, full-stall cycle limit; used only with the optional feature.

Ports:
- write_clk  input  1  clock; same clock as the FIFO write side.
- read_reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  01 PARK, 10 RETRIEVE, 11 CANCEL, 00 illegal.
- req_floor  input  4  target floor.
- req_slot  input  6  slot index.
- req_car_id  input  5  car tag.
- write_full  input  1  FIFO full flag (registered in the FIFO).
- write_enable  output  1  FIFO write strobe.
- write_data  output  DATASIZE  FIFO word.
- busy  output  1  high whenever state is not IDLE.
- done_cnt  output  CNT_W  requests fully written; wraps.
- drop_cnt  output  CNT_W  requests dropped; saturates at all-ones.
- stall_abort  output  1  one-cycle pulse on timeout abort; tied 0 when the optional feature is off.

Behaviour:
- Clock write_clk; reset read_reset_n, asynchronous, active-low.
- Reset values:
  - state IDLE, req_ready 1, write_enable 0, write_data 0, busy 0.
  - seq 0, done_cnt 0, drop_cnt 0, stall_abort 0, holding registers 0.
- FSM states: IDLE, HDR, PLD.
- IDLE:
  - req_ready=1, write_enable=0.
  - On req_valid with op!=00: capture op, floor, slot and car_id into holding registers; next state HDR.
  - On req_valid with op==00: consume the request (ready was high), increment drop_cnt, remain in IDLE; no FIFO write.
- HDR:
  - req_ready=0, write_enable=1, write_data = {1'b1, op, floor, seq}.
  - If write_full=0, the word is accepted this edge; go to PLD.
  - Otherwise hold the state and the word unchanged.
- PLD:
  - write_enable=1, write_data = {1'b0, slot, car_id}.
  - If write_full=0, go to IDLE, increment seq (wraps at 2^SEQ_W), increment done_cnt.
  - Otherwise hold.
- write_enable and write_data are combinational from state and holding registers; write_data is 0 in IDLE.
- Acceptance rule matches the FIFO: a word counts as written exactly when write_enable && !write_full at the edge.
- Minimum three cycles per request: IDLE, HDR, PLD; no back-to-back overlap.
- The header bit (bit 11) marks the start of frame. The consumer resynchronises on bit 11 = 1.
- Reset mid-frame returns the FSM to IDLE immediately. A header already in the FIFO without its payload is expected to be discarded by the consumer via the start-of-frame bit.
- Inputs are sampled only at the IDLE handshake. Later changes to req_* have no effect.

Optional Feature:
- Macro: LIFT_REQ_STALL_TIMEOUT_EN.
- Defined:
  - An 8-bit stall counter counts consecutive HDR cycles with write_full=1.
  - When the count reaches STALL_LIMIT, abort: go to IDLE, pulse stall_abort, increment drop_cnt. seq is unchanged.
  - The counter clears on any state change.
  - No timeout applies in PLD; the payload must complete once its header is written.
- Undefined: no stall counter; HDR waits indefinitely; stall_abort is constant 0.

Decomposition:
- Package lift_req_pkg contains:
  - op enum: OP_ILLEGAL=00, OP_PARK=01, OP_RETRIEVE=10, OP_CANCEL=11.
  - state enum: IDLE, HDR, PLD.
  - field-position localparams: SOF bit 11, op [10:9], floor [8:5], seq [4:0]; slot [10:5], car_id [4:0].
  - functions pack_hdr() and pack_pld().
- No sub-module. Counters and FSM live in one module; the FIFO is instantiated alongside it at the parent level.

Test Plan:
- PARK, floor 3, slot 0x2A, car 0x15, write_full=0 → writes 0xA60 then 0x555 on consecutive cycles; done_cnt=1; seq=1.
- Second request RETRIEVE, floor 15, same slot/car → header 0xDE1, payload 0x555; done_cnt=2.
- Hold write_full=1 for 4 cycles in HDR → write_enable held, data stable at the header, no advance; resumes the cycle after full drops.
- req_op=00 → req_ready=1, no write_enable, drop_cnt 0→1, state stays IDLE.
- Assert read_reset_n=0 during PLD → all outputs at reset values asynchronously; the next request starts with seq 0.
- With LIFT_REQ_STALL_TIMEOUT_EN and STALL_LIMIT=5, write_full held high → stall_abort pulses after 5 HDR cycles; drop_cnt +1; back in IDLE.
